// File: rtl/dmem_store_log.sv
// Data memory for the pipelined MIPS core's memory port. Every store is also appended
// to a show-ahead FIFO log, stamped with a free-running cycle count.
module dmem_store_log #(
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         memwrite_i,
    input  logic [31:0]                  dataadr_i,
    input  logic [31:0]                  writedata_i,
    output logic [31:0]                  readdata_o,
    input  logic                         log_pop_i,
    output logic                         log_valid_o,
    output logic [31:0]                  log_adr_o,
    output logic [31:0]                  log_data_o,
    output logic [31:0]                  log_cycle_o,
    output logic [$clog2(LOG_DEPTH):0]   log_count_o,
    output logic                         log_overflow_o,
    output logic                         addr_err_o
);

    localparam int unsigned AdrW = $clog2(MEM_WORDS);
    localparam int unsigned PtrW = $clog2(LOG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     mem_q [MEM_WORDS];
    logic [31:0]     log_adr_q  [LOG_DEPTH];
    logic [31:0]     log_data_q [LOG_DEPTH];
    logic [31:0]     log_cyc_q  [LOG_DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     cyc_q, cyc_d;
    logic            overflow_q, overflow_d;
    logic            addr_err_q, addr_err_d;

    logic            in_range;
    logic [AdrW-1:0] word_idx;
    logic            full;
    logic            not_empty;
    logic            pop;
    logic            push;

    // Any set bit above the word-index field addresses past the end of the array.
    assign in_range  = (dataadr_i[31:AdrW+2] == '0);
    assign word_idx  = dataadr_i[AdrW+1:2];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CntW'(LOG_DEPTH));
    assign pop       = log_pop_i & not_empty;
    // A full log still accepts a store when the head leaves in the same cycle.
    assign push      = memwrite_i & ~reset_i & (~full | pop);

    always_comb begin
        readdata_o = '0;
        if (in_range) begin
            readdata_o = mem_q[word_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && memwrite_i && in_range) begin
            mem_q[word_idx] <= writedata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            log_adr_q[wr_ptr_q]  <= dataadr_i;
            log_data_q[wr_ptr_q] <= writedata_i;
            log_cyc_q[wr_ptr_q]  <= cyc_q;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        cyc_d      = cyc_q + 32'd1;
        overflow_d = overflow_q | (memwrite_i & full & ~pop);
        addr_err_d = addr_err_q | (memwrite_i & ~in_range);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        log_adr_o   = '0;
        log_data_o  = '0;
        log_cycle_o = '0;
        if (not_empty) begin
            log_adr_o   = log_adr_q[rd_ptr_q];
            log_data_o  = log_data_q[rd_ptr_q];
            log_cycle_o = log_cyc_q[rd_ptr_q];
        end
    end

    assign log_valid_o    = not_empty;
    assign log_count_o    = count_q;
    assign log_overflow_o = overflow_q;
    assign addr_err_o     = addr_err_q;

endmodule

// File: doc/dmem_store_log.md
# dmem_store_log

Data-memory responder for the pipelined MIPS core's memory port (`memwrite`, `dataadr`, `writedata`, `readdata`). It services loads and stores from the core and records every store in a first-in, first-out (FIFO) log, stamped with a cycle count. A bench or host drains the log through a pop handshake, so store sequences can be checked in order instead of being sampled on a clock edge. The block sits in `top` in place of the plain data memory.

## Interface
- `MEM_WORDS`, 64: number of 32-bit words in the memory array (power of two).
- `LOG_DEPTH`, 8: number of entries in the store-log FIFO (power of two, at least 2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the core, one store per cycle while high.
- `dataadr`  in  32  byte address from the core.
- `writedata`  in  32  store data from the core.
- `readdata`  out  32  load data returned to the core.
- `log_pop`  in  1  consume the head log entry; ignored when `log_valid` is 0.
- `log_valid`  out  1  the log holds at least one entry.
- `log_adr`  out  32  full `dataadr` of the head entry.
- `log_data`  out  32  `writedata` of the head entry.
- `log_cycle`  out  32  cycle stamp of the head entry.
- `log_count`  out  clog2(LOG_DEPTH)+1  number of occupied log entries.
- `log_overflow`  out  1  sticky: a store was dropped because the log was full.
- `addr_err`  out  1  sticky: a store targeted a word index of `MEM_WORDS` or above.

## Operation
- **Word index.** The word index is `dataadr[31:2]`. The low two address bits are ignored for memory access but kept in the log.
- **Loads.** `readdata` is a combinational read of `mem[dataadr[clog2(MEM_WORDS)+1:2]]`. An out-of-range index returns 0.
- **Stores.** When `memwrite`=1 and the index is in range, `mem[index]` is written with `writedata` on the edge. When the index is out of range, the memory is unchanged and `addr_err` is set.
- **Logging.** Every store, in range or not, pushes {`dataadr`, `writedata`, `cyc`} into the log.
- **Cycle counter.** `cyc` is a 32-bit free-running counter: 0 in the first cycle after reset, incrementing every cycle, wrapping from 2^32-1 to 0.
- **Log head.** The log is show-ahead. `log_adr`, `log_data` and `log_cycle` always present the oldest entry. When the log is empty they read 0.
- **Pop.** When `log_pop`=1 and `log_valid`=1, the head entry is removed on the edge.
- **Full log.**
  - Push without a pop: the new store is still written to memory, but not logged, and `log_overflow` is set.
  - Push with a valid pop in the same cycle: both are performed, and the count stays at `LOG_DEPTH`.
- **Empty log.** `log_pop` is ignored; no underflow can occur.
- **Push and pop in the same cycle, not full:** the count is unchanged, and the head advances in order.
- **Pointers.** The read and write pointers wrap modulo `LOG_DEPTH`. A separate count register, or an extra pointer bit, distinguishes full from empty.
- **Reset.**
  - `log_valid`=0, `log_count`=0, head outputs = 0, `log_overflow`=0, `addr_err`=0, `cyc`=0.
  - Memory contents are not cleared.
  - A reset mid-operation discards all log entries.
  - A store presented in the reset cycle is neither written nor logged.

## Timing
- **Load latency:** 0 cycles. `readdata` follows `dataadr` combinationally. A store to address A at edge N is visible on `readdata` for address A from edge N onward.
- **Push to visible:** 1 edge. A store sampled at edge N makes `log_valid`=1 and `log_count` increment immediately after edge N.
- **Pop to next head:** 1 edge. After a pop at edge N, the next entry is on the head outputs immediately after edge N.
- **Sticky flags:** set at the edge of the offending store; cleared only by reset.
- **Cycle stamp:** equals the value of `cyc` in the cycle `memwrite` is sampled.

## Test plan
- **Single store.**
  - Stimulus: reset for 2 cycles, release, then in the 3rd cycle after release drive `memwrite`=1, `dataadr`=60, `writedata`=230.
  - Required: `readdata` at address 60 = 230; `log_valid`=1, `log_adr`=60, `log_data`=230, `log_cycle`=2, `log_count`=1.
- **Two stores in order.**
  - Stimulus: store (60, 230), then store (61, 29); pop twice.
  - Required: heads are (60, 230), then (61, 29). `readdata` at address 60 = 29, since address 61 maps to the same word. `log_valid`=0 after the second pop.
- **Overflow.**
  - Stimulus: 9 consecutive stores to addresses 0, 4, …, 32 with no pops.
  - Required: `log_count`=8, `log_overflow`=1. Draining yields 8 entries, addresses 0 through 28. Memory still holds the store at address 32.
- **Full with push and pop.**
  - Stimulus: with the log full, push one store and pop in the same cycle.
  - Required: `log_count` stays 8, `log_overflow` stays 0, the oldest entry is removed, and the new entry ends up at the tail.
- **Out of range.**
  - Stimulus: store (0x100, 7) with `MEM_WORDS`=64.
  - Required: `addr_err`=1, no memory word changes, the store is logged with `log_adr`=0x100.
- **Reset mid-drain.**
  - Stimulus: 3 entries queued, pop once, then assert reset for 1 cycle.
  - Required: `log_count`=0, `log_valid`=0, flags cleared, `cyc` restarts at 0, and memory data survives.
